// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: bullet slot pool with fire allocation and a serial
// erase/move/draw sweep sharing one valid/ready plot port.
module bullet_pool_ctrl #(
    parameter int NUM_SLOTS = 8,
    parameter int IDX_W     = 3,
    parameter int COOLDOWN  = 4,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fire,
    input  logic [1:0]           dir_x,
    input  logic [1:0]           dir_y,
    input  logic [7:0]           ship_x,
    input  logic [6:0]           ship_y,
    output logic                 fire_ack,
    input  logic                 move_tick,
    input  logic                 kill,
    input  logic [IDX_W-1:0]     kill_idx,
    output logic [7:0]           plot_x,
    output logic [6:0]           plot_y,
    output logic                 plot_colour,
    output logic                 plot_valid,
    input  logic                 plot_ready,
    output logic [NUM_SLOTS-1:0] active_mask,
    output logic                 sweep_done
);
    localparam int CW = $clog2(COOLDOWN + 1);

    typedef enum logic [2:0] {IDLE, SCAN, ERASE, MOVE, DRAW, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [CW-1:0]        cool_q;
    logic                 fire_ack_q;
    logic [NUM_SLOTS-1:0] active_q, dying_q, drawn_q;
    logic [7:0]           x_q  [NUM_SLOTS];
    logic [6:0]           y_q  [NUM_SLOTS];
    logic [1:0]           dx_q [NUM_SLOTS];
    logic [1:0]           dy_q [NUM_SLOTS];

    logic             accept, adv, free_s, edge_hit, last;
    logic [IDX_W-1:0] free_idx;
    logic [7:0]       nx;
    logic [6:0]       ny;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!active_q[i]) free_idx = IDX_W'(i);
    end

    assign accept   = fire && state_q == IDLE && cool_q == '0 && !(&active_q) && !move_tick;
    assign nx       = dx_q[idx_q] == 2'b01 ? x_q[idx_q] + 8'd1 :
                      dx_q[idx_q] == 2'b10 ? x_q[idx_q] - 8'd1 : x_q[idx_q];
    assign ny       = dy_q[idx_q] == 2'b01 ? y_q[idx_q] + 7'd1 :
                      dy_q[idx_q] == 2'b10 ? y_q[idx_q] - 7'd1 : y_q[idx_q];
    assign edge_hit = nx == 8'd0 || nx == 8'(X_MAX) || ny == 7'd0 || ny == 7'(Y_MAX);
    assign last     = idx_q == IDX_W'(NUM_SLOTS - 1);

    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;

    // adv: current slot is finished this cycle; free_s: it is released as well
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        free_s  = 1'b0;
        case (state_q)
            IDLE: state_d = move_tick ? SCAN : IDLE;
            SCAN: begin
                free_s  = active_q[idx_q] && dying_q[idx_q] && !drawn_q[idx_q];
                adv     = !active_q[idx_q] || free_s;
                state_d = drawn_q[idx_q] ? ERASE : MOVE;
            end
            ERASE: begin
                adv     = plot_ready && dying_q[idx_q];
                free_s  = adv;
                state_d = plot_ready ? MOVE : ERASE;
            end
            MOVE: begin
                adv     = edge_hit;
                free_s  = edge_hit;
                state_d = DRAW;
            end
            DRAW:    adv = plot_ready;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (adv) state_d = last ? DONE : SCAN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= '0;
            dying_q    <= '0;
            drawn_q    <= '0;
            cool_q     <= '0;
            idx_q      <= '0;
            fire_ack_q <= 1'b0;
        end else begin
            fire_ack_q <= accept;
            if (state_q == IDLE && move_tick) begin
                idx_q  <= '0;
                cool_q <= cool_q == '0 ? '0 : cool_q - 1'b1;
            end
            if (accept) begin
                cool_q             <= CW'(COOLDOWN);
                active_q[free_idx] <= 1'b1;
                dying_q[free_idx]  <= 1'b0;
                drawn_q[free_idx]  <= 1'b0;
                x_q[free_idx]      <= ship_x;
                y_q[free_idx]      <= ship_y;
                dx_q[free_idx]     <= dir_x;
                dy_q[free_idx]     <= dir_y;
            end
            if (kill && active_q[kill_idx]) dying_q[kill_idx] <= 1'b1;
            if (adv) idx_q <= idx_q + 1'b1;
            if (state_q == MOVE && !edge_hit) begin
                x_q[idx_q] <= nx;
                y_q[idx_q] <= ny;
            end
            if (state_q == DRAW && plot_ready) drawn_q[idx_q] <= 1'b1;
            // freeing overrides a same-cycle kill on that slot
            if (free_s) begin
                active_q[idx_q] <= 1'b0;
                dying_q[idx_q]  <= 1'b0;
                drawn_q[idx_q]  <= 1'b0;
            end
        end
    end

    always_comb begin
        plot_valid  = state_q == ERASE || state_q == DRAW;
        plot_colour = state_q == DRAW;
        plot_x      = plot_valid ? x_q[idx_q] : 8'd0;
        plot_y      = plot_valid ? y_q[idx_q] : 7'd0;
        sweep_done  = state_q == DONE;
        fire_ack    = fire_ack_q;
        active_mask = active_q;
    end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// tb_bullet_pool_ctrl: scoreboard bench; a slot model predicts each sweep's
// plots into a queue that is drained as the DUT's plots are accepted.
module tb_bullet_pool_ctrl;
    localparam int N = 8;
    localparam int COOL = 4;

    logic       clk = 0, reset = 1, fire = 0, move_tick = 0, kill = 0, plot_ready = 0;
    logic [1:0] dir_x = 0, dir_y = 0;
    logic [7:0] ship_x = 0;
    logic [6:0] ship_y = 0;
    logic [2:0] kill_idx = 0;
    logic       fire_ack, plot_colour, plot_valid, sweep_done;
    logic [7:0] plot_x, active_mask;
    logic [6:0] plot_y;

    bullet_pool_ctrl dut (
        .clk(clk), .reset(reset), .fire(fire), .dir_x(dir_x), .dir_y(dir_y),
        .ship_x(ship_x), .ship_y(ship_y), .fire_ack(fire_ack), .move_tick(move_tick),
        .kill(kill), .kill_idx(kill_idx), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot_valid(plot_valid), .plot_ready(plot_ready),
        .active_mask(active_mask), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_plot;
    bit          m_act[N], m_dying[N], m_drawn[N];
    logic [7:0]  m_x[N];
    logic [6:0]  m_y[N];
    logic [1:0]  m_dx[N], m_dy[N];
    int          m_cool;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] m_mask();
        logic [7:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = m_act[i];
        return m;
    endfunction

    function automatic logic [7:0] step_x(input logic [7:0] v, input logic [1:0] d);
        return d == 2'b01 ? v + 8'd1 : d == 2'b10 ? v - 8'd1 : v;
    endfunction

    function automatic logic [6:0] step_y(input logic [6:0] v, input logic [1:0] d);
        return d == 2'b01 ? v + 7'd1 : d == 2'b10 ? v - 7'd1 : v;
    endfunction

    task automatic m_free(input int i);
        m_act[i] = 0; m_dying[i] = 0; m_drawn[i] = 0;
    endtask

    task automatic model_sweep();
        if (m_cool > 0) m_cool--;
        for (int i = 0; i < N; i++) begin
            logic [7:0] nx;
            logic [6:0] ny;
            if (!m_act[i]) continue;
            if (m_drawn[i]) exp_q.push_back({1'b0, m_x[i], m_y[i]});
            if (m_dying[i]) begin m_free(i); continue; end
            nx = step_x(m_x[i], m_dx[i]);
            ny = step_y(m_y[i], m_dy[i]);
            if (nx == 0 || nx == 159 || ny == 0 || ny == 119) begin m_free(i); continue; end
            m_x[i] = nx; m_y[i] = ny; m_drawn[i] = 1;
            exp_q.push_back({1'b1, nx, ny});
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1;
        repeat (2) @(negedge clk);
        check("reset_outs", {fire_ack, plot_valid, plot_colour, plot_x, plot_y, active_mask, sweep_done},
              32'd0);
        reset = 0;
        for (int i = 0; i < N; i++) m_free(i);
        m_cool = 0;
    endtask

    task automatic do_fire(input logic [7:0] x, input logic [6:0] y, input logic [1:0] dx,
                           input logic [1:0] dy);
        bit ok = m_cool == 0 && m_mask() != 8'hff;
        @(negedge clk) begin fire = 1; ship_x = x; ship_y = y; dir_x = dx; dir_y = dy; end
        @(negedge clk) fire = 0;
        check("fire_ack", fire_ack, ok);
        if (ok) begin
            for (int i = 0; i < N; i++)
                if (!m_act[i]) begin
                    m_act[i] = 1; m_dying[i] = 0; m_drawn[i] = 0;
                    m_x[i] = x; m_y[i] = y; m_dx[i] = dx; m_dy[i] = dy;
                    break;
                end
            m_cool = COOL;
            @(negedge clk) check("ack_pulse", fire_ack, 0);
        end
        check("fire_mask", active_mask, m_mask());
    endtask

    task automatic do_kill(input int i);
        @(negedge clk) begin kill = 1; kill_idx = 3'(i); end
        @(negedge clk) kill = 0;
        if (m_act[i]) m_dying[i] = 1;
    endtask

    task automatic do_tick(input int wait_n, input bit fire_too);
        bit          done = 0;
        int          wcnt = 0;
        logic [15:0] cur, held = '0;
        model_sweep();
        @(negedge clk) begin move_tick = 1; fire = fire_too; end
        @(negedge clk) begin move_tick = 0; fire = 0; end
        if (fire_too) check("fire_vs_tick", fire_ack, 0);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (sweep_done) done = 1;
            else if (plot_valid) begin
                cur = {plot_colour, plot_x, plot_y};
                if (wcnt > 0) check("plot_hold", cur, held);
                if (wcnt < wait_n) begin
                    held = cur; wcnt++; plot_ready = 0;
                end else begin
                    check("plot", {16'h0, cur},
                          exp_q.size() > 0 ? {16'h0, exp_q.pop_front()} : 32'hdead_0000);
                    last_plot = cur; plot_ready = 1; wcnt = 0;
                end
            end else plot_ready = 0;
        end
        plot_ready = 0;
        check("sweep_done", done, 1);
        check("plots_left", exp_q.size(), 0);
        check("sweep_mask", active_mask, m_mask());
        @(negedge clk) check("done_pulse", sweep_done, 0);
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        do_reset();
        // single bullet: spawn, draw, then erase+draw with a stalled writer
        do_fire(8'd50, 7'd60, 2'b01, 2'b00);
        check("t1_mask", active_mask, 8'h01);
        do_fire(8'd70, 7'd70, 2'b00, 2'b00);
        do_tick(0, 0);
        check("t1_draw", last_plot, {1'b1, 8'd51, 7'd60});
        do_tick(5, 0);
        check("t2_draw", last_plot, {1'b1, 8'd52, 7'd60});
        do_fire(8'd70, 7'd70, 2'b00, 2'b00);

        // reaching the right edge frees the slot without drawing
        do_reset();
        do_fire(8'd158, 7'd50, 2'b01, 2'b00);
        do_tick(0, 0);
        check("t3_mask", active_mask, 8'h00);

        // fire coinciding with move_tick is dropped, then fill the pool
        do_reset();
        do_tick(0, 1);
        check("t4_nofire", active_mask, 8'h00);
        for (int i = 0; i < N; i++) begin
            do_fire(8'(60 + 4 * i), 7'd50, 2'(i % 3), 2'((i + 1) % 3));
            repeat (4) do_tick(0, 0);
        end
        check("t4_full", active_mask, 8'hff);
        do_fire(8'd10, 7'd10, 2'b01, 2'b00);

        // kill a drawn slot, kill it again while free, then reuse it
        do_kill(2);
        do_tick(2, 0);
        check("t5_freed", active_mask, 8'hfb);
        do_kill(2);
        do_fire(8'd100, 7'd100, 2'b00, 2'b00);
        check("t5_reuse", active_mask, 8'hff);
        do_tick(1, 0);

        // reset while a draw is stalled
        do_reset();
        do_fire(8'd30, 7'd30, 2'b01, 2'b01);
        @(negedge clk) move_tick = 1;
        @(negedge clk) move_tick = 0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = plot_valid;
        end
        check("t6_draw_wait", {plot_valid, plot_colour, plot_x, plot_y}, {1'b1, 1'b1, 8'd31, 7'd31});
        reset = 1;
        @(negedge clk);
        check("t6_reset", {plot_valid, active_mask, sweep_done}, 10'd0);
        reset = 0;
        for (int i = 0; i < N; i++) m_free(i);
        m_cool = 0;
        do_fire(8'd40, 7'd40, 2'b00, 2'b00);
        check("t6_mask", active_mask, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
